mux_nch_rr: RTL and testbench
=============================

# mux_nch_rr

Parametrised N-channel, W-bit registered multiplexer: the next generation of the team's combinational 4:1 muxes. It selects one of N valid/ready input channels, either by an external select or by a round-robin arbiter, and delivers the chosen word through a one-entry output register with a valid/ready handshake. It sits between several producers and a single shared consumer, such as a UART TX or display driver.

## Interface
- N, default 4: number of input channels, 2..16.
- W, default 8: data width per channel, 1..32.
- SW, derived (localparam) = clog2(N): select / channel-index width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- x  in  N*W  packed channel data; channel i is x[i*W +: W].
- x_valid  in  N  per-channel request.
- x_ready  out  N  per-channel accept; at most one bit is high.
- mode  in  1  0 = fixed select by s; 1 = round-robin.
- s  in  SW  channel select, used only when mode = 0.
- y  out  W  registered output data.
- y_ch  out  SW  source channel of y.
- y_valid  out  1  y/y_ch hold a word.
- y_ready  in  1  consumer accept.

## Operation
- Output register states: EMPTY (y_valid = 0) and FULL (y_valid = 1).
- load_en = ~y_valid | y_ready. A drain and a refill in the same cycle are legal and give full throughput.
- Grant (combinational, evaluated every cycle):
  - mode 0: grant channel s if s < N and x_valid[s]; otherwise no grant. If s ≥ N (N not a power of 2), there is never a grant.
  - mode 1: scan from (ptr+1) mod N upward, wrapping; the first channel with x_valid set wins.
- x_ready[g] = load_en & grant_valid for the granted channel g; all other bits are 0. x_ready is combinational from x_valid, mode, s, y_valid, y_ready and ptr.
- Transfer on channel g happens when x_valid[g] & x_ready[g]:
  - y <= x[g], y_ch <= g, y_valid <= 1.
  - ptr <= g, in mode 1 only.
- When y_valid & y_ready and there is no new transfer, y_valid <= 0. y and y_ch hold their last values.
- ptr (SW bits, internal) holds the last round-robin grant. It is not changed by mode-0 transfers.
- A mode or s change takes effect on the same cycle's grant. There is no state flush.
- While FULL and y_ready = 0: y, y_ch and y_valid are stable, and all x_ready are 0.
- Data must be honoured even if the producer changes x while x_valid = 0. Only transferred words are sampled.

## Timing
- Reset (asynchronous assert; release synchronous to clk):
  - y = 0, y_ch = 0, y_valid = 0, ptr = N-1, so channel 0 has first round-robin priority.
  - x_ready = 0 while rst is high.
- Reset mid-operation: any held word is discarded, with no output. The first transfer after release follows the reset ptr.
- Latency: the input accepted at edge k appears on y with y_valid = 1 after edge k, i.e. 1 cycle.
- Throughput: 1 word per cycle with y_ready held at 1.
- Fairness (mode 1, all N channels valid continuously): grants go 0,1,…,N-1,0,… Any valid channel waits at most N-1 transfers.
- Wrap-around: ptr = N-1 with channel 0 valid selects 0. ptr = g with only channel g valid re-grants g.

## Test plan
- Reset: assert rst mid-stream with y_valid = 1 -> y = 0, y_ch = 0, y_valid = 0 immediately (before the next edge). After release with all valid in mode 1 -> first grant is channel 0.
- Fixed select: N = 4, W = 8, mode = 0, s = 2, x = {8'hD3, 8'hC2, 8'hB1, 8'hA0}, all valid, y_ready = 1 -> x_ready = 4'b0100 and y = 8'hC2, y_ch = 2 next cycle. With s = 2 but x_valid[2] = 0 -> x_ready = 0 and y_valid falls.
- Round-robin fairness: mode 1, x_valid = 4'b1111, y_ready = 1 for 8 cycles -> y_ch sequence 0,1,2,3,0,1,2,3 and y_valid = 1 throughout.
- Sparse/wrap: mode 1, x_valid = 4'b1001, ptr = 3 after reset-driven grants -> grants alternate 0,3,0,3. With only channel 2 valid -> 2,2,2.
- Backpressure: y_valid = 1 and y_ready = 0 for 5 cycles -> y and y_ch stable, x_ready = 0. On y_ready = 1 with a new input valid -> drain and refill in one cycle, with no bubble.
- Non-power-of-2: N = 3, mode 0, s = 3 -> no grant ever, y_valid = 0. Mode 1 -> sequence 0,1,2,0.

Source files
------------

// File: rtl/mux_nch_rr.sv
// mux_nch_rr: N-channel, W-bit multiplexer with a one-entry registered output.
// A channel is chosen either by the external select s (mode 0) or by a
// round-robin scan starting after the last round-robin grant (mode 1). The
// chosen word is captured into the output register under a valid/ready
// handshake. Drain and refill can happen in the same cycle.
module mux_nch_rr #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] x,
  input  logic [N-1:0]   x_valid,
  output logic [N-1:0]   x_ready,
  input  logic           mode,
  input  logic [SW-1:0]  s,
  output logic [W-1:0]   y,
  output logic [SW-1:0]  y_ch,
  output logic           y_valid,
  input  logic           y_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  logic [SW-1:0]   ptr;
  logic            load_en;
  logic            grant_valid;
  logic [SW-1:0]   grant_idx;
  logic [W-1:0]    sel_data;
  logic            transfer;
  logic [2*N-1:0]  dbl;
  logic [2*N-1:0]  rot;

  assign y_valid  = (state == FULL);
  assign load_en  = (state == EMPTY) | y_ready;
  assign transfer = grant_valid & load_en;
  assign dbl      = {x_valid, x_valid};

  // Grant selection: fixed select in mode 0, rotating priority in mode 1.
  // The round-robin scan rotates a doubled copy of x_valid so bit k of rot is
  // channel (ptr+1+k) mod N; scanning k downward leaves the lowest k winning.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rot         = '0;
    if (mode == 1'b0) begin
      grant_idx = s;
      // An out-of-range s matches no channel, so it never grants.
      for (int i = 0; i < N; i++) begin
        grant_valid = (int'(s) == i) ? x_valid[i] : grant_valid;
      end
    end else begin
      rot         = dbl >> (int'(ptr) + 1);
      grant_valid = |x_valid;
      for (int k = N - 1; k >= 0; k--) begin
        grant_idx = rot[k] ? SW'((int'(ptr) + 1 + k) % N) : grant_idx;
      end
    end
  end

  // Data of the granted channel, picked with constant slices only.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = (int'(grant_idx) == i) ? x[i*W +: W] : sel_data;
    end
  end

  // Per-channel accept: only the granted channel, only when the register can load.
  always_comb begin
    x_ready = '0;
    for (int i = 0; i < N; i++) begin
      x_ready[i] = ~rst & load_en & grant_valid & (int'(grant_idx) == i);
    end
  end

  // Output register state machine plus round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      y     <= '0;
      y_ch  <= '0;
      ptr   <= SW'(N - 1);
    end else begin
      case (state)
        EMPTY: begin
          if (transfer) begin
            state <= FULL;
            y     <= sel_data;
            y_ch  <= grant_idx;
            ptr   <= mode ? grant_idx : ptr;
          end else begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (transfer) begin
            state <= FULL;
            y     <= sel_data;
            y_ch  <= grant_idx;
            ptr   <= mode ? grant_idx : ptr;
          end else if (y_ready) begin
            state <= EMPTY;
          end else begin
            state <= FULL;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nch_rr.sv
// Testbench for mux_nch_rr: directed vectors, expected outputs queued by the
// stimulus and popped by independent monitors whenever a word is handed off.
module tb_mux_nch_rr;

  logic        clk = 1'b0;
  logic        rst;

  // N=4 instance
  logic [31:0] x;
  logic [3:0]  x_valid;
  logic [3:0]  x_ready;
  logic        mode;
  logic [1:0]  s;
  logic [7:0]  y;
  logic [1:0]  y_ch;
  logic        y_valid;
  logic        y_ready;

  // N=3 instance
  logic [23:0] x3;
  logic [2:0]  xv3;
  logic [2:0]  xr3;
  logic        mode3;
  logic [1:0]  s3;
  logic [7:0]  y3;
  logic [1:0]  ych3;
  logic        yv3;
  logic        yr3;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] q[$];
  logic [15:0] q3[$];
  logic [7:0]  exp_d[4]  = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic [7:0]  exp_d3[3] = '{8'h11, 8'h22, 8'h33};
  int          sp_ch[7]  = '{0, 3, 0, 3, 2, 2, 2};
  int          n3_ch[4]  = '{0, 1, 2, 0};

  mux_nch_rr #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .mode(mode), .s(s), .y(y), .y_ch(y_ch), .y_valid(y_valid), .y_ready(y_ready)
  );

  mux_nch_rr #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .x(x3), .x_valid(xv3), .x_ready(xr3),
    .mode(mode3), .s(s3), .y(y3), .y_ch(ych3), .y_valid(yv3), .y_ready(yr3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the N=4 instance: every handed-off word must match the queue head.
  always @(negedge clk) begin
    if (!rst && y_valid && y_ready) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_out4: got ch %0d data %0h with nothing expected", y_ch, y);
      end else begin
        logic [15:0] e;
        e = q.pop_front();
        chk("out4_ch", 32'(y_ch), 32'(e[15:8]));
        chk("out4_data", 32'(y), 32'(e[7:0]));
      end
    end
  end

  // Monitor for the N=3 instance.
  always @(negedge clk) begin
    if (!rst && yv3 && yr3) begin
      if (q3.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_out3: got ch %0d data %0h with nothing expected", ych3, y3);
      end else begin
        logic [15:0] e;
        e = q3.pop_front();
        chk("out3_ch", 32'(ych3), 32'(e[15:8]));
        chk("out3_data", 32'(y3), 32'(e[7:0]));
      end
    end
  end

  initial begin
    rst = 1'b1; x = 32'hD3C2B1A0; x_valid = 4'h0; mode = 1'b0; s = 2'd0; y_ready = 1'b0;
    x3 = 24'h332211; xv3 = 3'b000; mode3 = 1'b0; s3 = 2'd0; yr3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    x_valid = 4'hF; mode = 1'b1;
    #1;
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_ych", 32'(y_ch), 32'h0);
    chk("rst_yvalid", 32'(y_valid), 32'h0);
    chk("rst_xready", 32'(x_ready), 32'h0);
    chk("rst_yvalid3", 32'(yv3), 32'h0);
    x_valid = 4'h0; mode = 1'b0;
    tick();
    rst = 1'b0;

    // Fixed select on channel 2
    mode = 1'b0; s = 2'd2; x_valid = 4'hF; y_ready = 1'b1;
    #1;
    chk("fix_xready", 32'(x_ready), 32'h4);
    q.push_back({8'd2, 8'hC2});
    tick();
    chk("fix_yvalid", 32'(y_valid), 32'h1);
    x_valid = 4'b1011;
    #1;
    chk("fix_novalid_xready", 32'(x_ready), 32'h0);
    tick();
    chk("fix_yvalid_fall", 32'(y_valid), 32'h0);

    // Round-robin fairness, all channels valid (ptr still at reset value 3)
    mode = 1'b1; x_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_xready", 32'(x_ready), 32'(1 << (i % 4)));
      q.push_back({8'(i % 4), exp_d[i % 4]});
      tick();
      chk("rr_yvalid", 32'(y_valid), 32'h1);
    end

    // Sparse wrap 0,3,0,3 then single channel 2 repeatedly
    for (int i = 0; i < 7; i++) begin
      x_valid = (i < 4) ? 4'b1001 : 4'b0100;
      #1;
      chk("sparse_xready", 32'(x_ready), 32'(1 << sp_ch[i]));
      q.push_back({8'(sp_ch[i]), exp_d[sp_ch[i]]});
      tick();
    end

    // Backpressure: held word C2 from channel 2 must stay put
    y_ready = 1'b0; x_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_xready", 32'(x_ready), 32'h0);
      chk("bp_y", 32'(y), 32'hC2);
      chk("bp_ych", 32'(y_ch), 32'h2);
      chk("bp_yvalid", 32'(y_valid), 32'h1);
      tick();
    end
    y_ready = 1'b1;
    #1;
    chk("refill_xready", 32'(x_ready), 32'h8);
    q.push_back({8'd3, 8'hD3});
    tick();
    chk("refill_ych", 32'(y_ch), 32'h3);
    chk("refill_yvalid", 32'(y_valid), 32'h1);
    x_valid = 4'h0;
    tick();
    chk("drain_yvalid", 32'(y_valid), 32'h0);

    // Reset mid-stream: load channel 0 (ptr 3 -> 0) while stalled, then reset
    y_ready = 1'b0; x_valid = 4'hF;
    tick();
    chk("pre_rst_yvalid", 32'(y_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_y", 32'(y), 32'h0);
    chk("mid_rst_ych", 32'(y_ch), 32'h0);
    chk("mid_rst_yvalid", 32'(y_valid), 32'h0);
    chk("mid_rst_xready", 32'(x_ready), 32'h0);
    tick();
    rst = 1'b0; y_ready = 1'b1;
    #1;
    chk("post_rst_xready", 32'(x_ready), 32'h1);
    q.push_back({8'd0, 8'hA0});
    tick();
    x_valid = 4'h0;
    tick();
    chk("post_rst_drain", 32'(y_valid), 32'h0);

    // N=3: out-of-range select never grants
    mode3 = 1'b0; s3 = 2'd3; xv3 = 3'b111; yr3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("n3_sel3_xready", 32'(xr3), 32'h0);
      tick();
      chk("n3_sel3_yvalid", 32'(yv3), 32'h0);
    end
    // N=3 round-robin 0,1,2,0; channel 0 data changes while idle must not leak
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("n3_rr_xready", 32'(xr3), 32'(1 << n3_ch[i]));
      q3.push_back({8'(n3_ch[i]), exp_d3[n3_ch[i]]});
      tick();
    end
    xv3 = 3'b000; x3 = 24'h3322EE;
    tick();
    tick();
    chk("n3_drain_yvalid", 32'(yv3), 32'h0);
    chk("n3_hold_y", 32'(y3), 32'h11);

    chk("q4_empty", 32'(q.size()), 32'h0);
    chk("q3_empty", 32'(q3.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
